// File: rtl/imm_ext_pkg.sv
// Shared types for the ID-stage immediate controller: extension modes, opcodes,
// FSM state encoding and the decoded entry held in the main/skid registers.
package imm_ext_pkg;

    localparam int XLEN_P  = 32;
    localparam int IMM_W_P = 16;

    typedef enum logic [1:0] {
        MODE_SIGN   = 2'b00,
        MODE_ZERO   = 2'b01,
        MODE_LUI    = 2'b10,
        MODE_BRANCH = 2'b11
    } mode_e;

    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } state_e;

    typedef struct packed {
        logic [XLEN_P-1:0] imm;
        mode_e             mode;
        logic              uses_imm;
    } entry_t;

    localparam entry_t ENTRY_NONE = '{imm: '0, mode: MODE_SIGN, uses_imm: 1'b0};

endpackage

// File: rtl/imm_ext_dec.sv
// Combinational opcode decoder: maps an opcode and its 16-bit immediate field
// to the extended immediate, extension mode and uses-immediate flag.
module imm_ext_dec
    import imm_ext_pkg::*;
(
    input  logic [5:0]         opcode_i,
    input  logic [IMM_W_P-1:0] imm_i,
    output entry_t             entry_o
);

    always_comb begin
        entry_o = ENTRY_NONE;
        case (opcode_i)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: begin
                entry_o.imm      = {{(XLEN_P-IMM_W_P){imm_i[IMM_W_P-1]}}, imm_i};
                entry_o.mode     = MODE_SIGN;
                entry_o.uses_imm = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                entry_o.imm      = {{(XLEN_P-IMM_W_P){1'b0}}, imm_i};
                entry_o.mode     = MODE_ZERO;
                entry_o.uses_imm = 1'b1;
            end
            OP_LUI: begin
                entry_o.imm      = {imm_i, {(XLEN_P-IMM_W_P){1'b0}}};
                entry_o.mode     = MODE_LUI;
                entry_o.uses_imm = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                // Word offset: sign-extended and shifted left by two.
                entry_o.imm      = {{(XLEN_P-IMM_W_P-2){imm_i[IMM_W_P-1]}}, imm_i, 2'b00};
                entry_o.mode     = MODE_BRANCH;
                entry_o.uses_imm = 1'b1;
            end
            default: begin
                entry_o = ENTRY_NONE;
            end
        endcase
    end

endmodule

// File: rtl/imm_ext_ctrl.sv
// ID-stage immediate controller with a 2-entry skid buffer toward ID/EX.
// Define IMM_EXT_CNT_EN to add the saturating accepted-instruction counter acc_cnt.
module imm_ext_ctrl
    import imm_ext_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IMM_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [1:0]       out_mode,
    output logic             out_uses_imm,
`ifdef IMM_EXT_CNT_EN
    output logic [CNT_W-1:0] acc_cnt,
`endif
    output state_e           dbg_state
);

    // Handshake: a beat moves on in_valid & in_ready (accept) and on
    // out_valid & out_ready (pop); in_ready is a function of state only.

    state_e state_q, state_d;
    entry_t m_q, m_d;
    entry_t s_q, s_d;
    entry_t dec_entry;
    logic   accept;
    logic   pop;

    imm_ext_dec u_dec (
        .opcode_i (in_instr[31:26]),
        .imm_i    (in_instr[IMM_W-1:0]),
        .entry_o  (dec_entry)
    );

    logic unused_instr_bits;
    assign unused_instr_bits = ^in_instr[25:IMM_W];

    assign in_ready     = (state_q != ST_SKID);
    assign out_valid    = (state_q != ST_EMPTY);
    assign out_imm      = m_q.imm[XLEN-1:0];
    assign out_mode     = m_q.mode;
    assign out_uses_imm = m_q.uses_imm;
    assign dbg_state    = state_q;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (flush) begin
            // Squash wins over everything; a pop this cycle has already completed.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        m_d     = dec_entry;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && pop) begin
                        m_d = dec_entry;
                    end else if (accept) begin
                        s_d     = dec_entry;
                        state_d = ST_SKID;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (pop) begin
                        m_d     = s_q;
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            m_q     <= ENTRY_NONE;
            s_q     <= ENTRY_NONE;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

`ifdef IMM_EXT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !flush && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign acc_cnt = cnt_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// Bench for imm_ext_ctrl: directed test-plan sequences plus randomized traffic
// against a queue-based reference model.
module tb_imm_ext_ctrl;

    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_imm;
    logic [1:0]  out_mode;
    logic        out_uses_imm;
    logic [TB_CNT_W-1:0] acc_cnt;
    imm_ext_pkg::state_e dbg_state;

    imm_ext_ctrl #(.XLEN(32), .IMM_W(16), .CNT_W(TB_CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_imm      (out_imm),
        .out_mode     (out_mode),
        .out_uses_imm (out_uses_imm),
`ifdef IMM_EXT_CNT_EN
        .acc_cnt      (acc_cnt),
`endif
        .dbg_state    (dbg_state)
    );

`ifndef IMM_EXT_CNT_EN
    assign acc_cnt = '0;
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] imm;
        logic [1:0]  mode;
        logic        uses;
    } exp_t;

    exp_t q[$];
    int   cnt_m = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;
    bit   m_pop, m_acc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode written from the instruction-set meaning of each opcode.
    function automatic exp_t ref_dec(input logic [31:0] ins);
        exp_t        r;
        logic [15:0] i;
        int          s;
        i = ins[15:0];
        s = $signed(i);
        r = '0;
        case (ins[31:26])
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin
                r.imm = s; r.mode = 2'd0; r.uses = 1'b1;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                r.imm = 32'(i); r.mode = 2'd1; r.uses = 1'b1;
            end
            6'h0F: begin
                r.imm = 32'(i) * 32'd65536; r.mode = 2'd2; r.uses = 1'b1;
            end
            6'h04, 6'h05: begin
                r.imm = s * 4; r.mode = 2'd3; r.uses = 1'b1;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Model: a bounded queue of at most two decoded entries.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cnt_m = 0;
        end else begin
            m_pop = (q.size() > 0) && out_ready;
            m_acc = in_valid && (q.size() < 2);
            if (m_pop) void'(q.pop_front());
            if (flush) begin
                q.delete();
            end else if (m_acc) begin
                q.push_back(ref_dec(in_instr));
                if (cnt_m < CNT_MAX) cnt_m++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            if (q.size() > 0) begin
                chk("out_imm", 64'(out_imm), 64'(q[0].imm));
                chk("out_mode", 64'(out_mode), 64'(q[0].mode));
                chk("out_uses_imm", 64'(out_uses_imm), 64'(q[0].uses));
            end
`ifdef IMM_EXT_CNT_EN
            chk("acc_cnt", 64'(acc_cnt), 64'(cnt_m));
`endif
        end
    end

    task automatic step(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
        @(negedge clk);
        in_valid  = v;
        in_instr  = ins;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic v, input logic [31:0] imm,
                           input logic [1:0] mode, input logic uses);
        chk({nm, "_valid"}, 64'(out_valid), 64'(v));
        chk({nm, "_imm"}, 64'(out_imm), 64'(imm));
        chk({nm, "_mode"}, 64'(out_mode), 64'(mode));
        chk({nm, "_uses"}, 64'(out_uses_imm), 64'(uses));
    endtask

    localparam logic [31:0] I_A = 32'h2008FFFC;
    localparam logic [31:0] I_B = 32'h34088000;
    localparam logic [31:0] I_C = 32'h3C081234;

    logic [5:0] ops [16] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B, 6'h0C, 6'h0D,
                             6'h0E, 6'h0F, 6'h04, 6'h05, 6'h00, 6'h02, 6'h3F, 6'h20};

    initial begin
        exp_t        e;
        logic [31:0] r;
        logic        fl;

        // Pin the reference decoder itself with hand-computed values.
        e = ref_dec(32'h1000FFFF);
        chk("ref_beq", 64'(e), 64'({32'hFFFFFFFC, 2'd3, 1'b1}));
        e = ref_dec(32'h3C081234);
        chk("ref_lui", 64'(e), 64'({32'h12340000, 2'd2, 1'b1}));

        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 32'h0, 2'd0, 1'b0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        step(1, I_A, 1, 0);
        chk_out("addi", 1'b1, 32'hFFFFFFFC, 2'd0, 1'b1);

        step(1, I_B, 1, 0);
        chk_out("ori", 1'b1, 32'h00008000, 2'd1, 1'b1);
        step(1, I_C, 1, 0);
        chk_out("lui", 1'b1, 32'h12340000, 2'd2, 1'b1);
        step(1, 32'h1000FFFF, 1, 0);
        chk_out("beq", 1'b1, 32'hFFFFFFFC, 2'd3, 1'b1);
        step(0, 0, 1, 0);
        chk("drain_valid", 64'(out_valid), 64'd0);

        step(1, I_A, 0, 0);
        chk("stall1_ready", 64'(in_ready), 64'd1);
        step(1, I_B, 0, 0);
        chk("stall2_ready", 64'(in_ready), 64'd0);
        chk("stall2_imm", 64'(out_imm), 64'h00000000FFFFFFFC);
        step(1, I_C, 0, 0);
        chk("stall3_imm", 64'(out_imm), 64'h00000000FFFFFFFC);
        step(1, I_C, 1, 0);
        chk_out("unstall_b", 1'b1, 32'h00008000, 2'd1, 1'b1);
        step(1, I_C, 1, 0);
        chk_out("unstall_c", 1'b1, 32'h12340000, 2'd2, 1'b1);
        step(0, 0, 1, 0);
        chk("unstall_drain", 64'(out_valid), 64'd0);

        step(1, 32'h01095020, 1, 0);
        chk_out("rtype", 1'b1, 32'h0, 2'd0, 1'b0);
        step(0, 0, 1, 0);

        step(1, I_A, 0, 0);
        step(1, I_B, 0, 0);
        step(1, I_C, 0, 1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
`ifdef IMM_EXT_CNT_EN
        chk("flush_cnt", 64'(acc_cnt), 64'd10);
`endif
        step(0, 0, 1, 0);
        chk("flush_gone", 64'(out_valid), 64'd0);

        for (int k = 0; k < 1500; k++) begin
            r  = $urandom();
            fl = ($urandom_range(0, 31) == 0);
            step($urandom_range(0, 3) != 0, {ops[$urandom_range(0, 15)], r[25:0]},
                 (k % 200 < 20) ? 1'b0 : ($urandom_range(0, 3) != 0), fl);
        end

        step(1, I_A, 0, 0);
        step(1, I_B, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_out("midrst", 1'b0, 32'h0, 2'd0, 1'b0);
        chk("midrst_ready", 64'(in_ready), 64'd1);
`ifdef IMM_EXT_CNT_EN
        chk("midrst_cnt", 64'(acc_cnt), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step(1, I_A, 1, 0);
        chk_out("post_rst", 1'b1, 32'hFFFFFFFC, 2'd0, 1'b1);
`ifdef IMM_EXT_CNT_EN
        chk("post_rst_cnt", 64'(acc_cnt), 64'd1);
`endif
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
